// File: rtl/qeciphy_rx_lock_monitor.sv
// qeciphy_rx_lock_monitor: tracks training-word frame lock, remote readiness and lock-loss/timeout faults
module qeciphy_rx_lock_monitor #(
  parameter int          LOCK_COUNT   = 64,
  parameter int          GAP_LIMIT    = 256,
  parameter int          LOCK_TIMEOUT = 1048575,
  parameter logic [15:0] TRAIN_MARKER = 16'hB5A3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_enable_i,
  input  logic        rx_valid_i,
  input  logic [63:0] rx_data_i,
  output logic        rx_ready_o,
  output logic        remote_rx_ready_o,
  output logic        fault_fatal_o,
  output logic [2:0]  state_o
);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int GW = $clog2(GAP_LIMIT + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, HUNT = 3'd1, LOCKING = 3'd2, LOCKED = 3'd3, FAULT = 3'd4} state_t;
  state_t        r_state;
  logic [LW-1:0] r_lock;
  logic [GW-1:0] r_gap;
  logic [19:0]   r_tmo;
  logic          w_train;
  logic          w_unused;
  assign w_train  = rx_valid_i && (rx_data_i[63:48] == TRAIN_MARKER);
  assign w_unused = ^rx_data_i[47:1];
  assign state_o  = r_state;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state           <= IDLE;
      r_lock            <= '0;
      r_gap             <= '0;
      r_tmo             <= '0;
      rx_ready_o        <= 1'b0;
      remote_rx_ready_o <= 1'b0;
      fault_fatal_o     <= 1'b0;
    end else if (r_state == FAULT) begin
      r_state <= FAULT;
    end else if (!rx_enable_i) begin
      r_state           <= IDLE;
      r_lock            <= '0;
      r_gap             <= '0;
      r_tmo             <= '0;
      rx_ready_o        <= 1'b0;
      remote_rx_ready_o <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= HUNT;
          r_tmo   <= '0;
        end
        HUNT, LOCKING: begin
          r_tmo <= (r_tmo == '1) ? r_tmo : r_tmo + 20'd1;
          // timeout outranks a training word arriving on the final allowed cycle
          if (r_tmo >= 20'(LOCK_TIMEOUT - 1)) begin
            r_state       <= FAULT;
            fault_fatal_o <= 1'b1;
          end else if (w_train) begin
            r_lock <= r_lock + 1'b1;
            if (r_lock == LW'(LOCK_COUNT - 1)) begin
              r_state    <= LOCKED;
              r_gap      <= '0;
              rx_ready_o <= 1'b1;
            end else r_state <= LOCKING;
          end else if (rx_valid_i) begin
            r_state <= HUNT;
            r_lock  <= '0;
          end
        end
        LOCKED: begin
          if (!rx_valid_i && r_gap == GW'(GAP_LIMIT - 1)) begin
            r_state           <= FAULT;
            fault_fatal_o     <= 1'b1;
            rx_ready_o        <= 1'b0;
            remote_rx_ready_o <= 1'b0;
          end else begin
            r_gap <= rx_valid_i ? '0 : r_gap + 1'b1;
            if (w_train && rx_data_i[0]) remote_rx_ready_o <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qeciphy_rx_lock_monitor.sv
// tb_qeciphy_rx_lock_monitor: directed + randomized checks against a behavioural lock model
module tb_qeciphy_rx_lock_monitor;
  localparam int LC = 4, GL = 8, LT = 100;
  logic        clk = 1'b0;
  logic        rst, en, vld;
  logic [63:0] dat;
  logic        rdy, rrdy, flt;
  logic [2:0]  st;
  int          checks = 0, errors = 0;
  int          m_state, m_run, m_hunt, m_idle;
  bit          m_remote;

  qeciphy_rx_lock_monitor #(.LOCK_COUNT(LC), .GAP_LIMIT(GL), .LOCK_TIMEOUT(LT)) dut (
    .clk_i(clk), .rst_i(rst), .rx_enable_i(en), .rx_valid_i(vld), .rx_data_i(dat),
    .rx_ready_o(rdy), .remote_rx_ready_o(rrdy), .fault_fatal_o(flt), .state_o(st));

  always #5 clk = ~clk;

  function automatic logic [63:0] tw(bit f);
    return {16'hB5A3, 47'($urandom), f};
  endfunction
  function automatic logic [63:0] dw();
    logic [15:0] m;
    m = 16'hB5A3 ^ 16'($urandom_range(1, 65535));
    return {m, 48'($urandom) << 16 | 64'($urandom)};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
    end
  endtask

  // Reference: state named by meaning, run = consecutive training words since the last data word,
  // hunt = cycles spent searching, idle = consecutive empty cycles while locked.
  task automatic model_step();
    bit is_train;
    is_train = vld && dat[63:48] == 16'hB5A3;
    if (rst) begin
      m_state = 0; m_run = 0; m_hunt = 0; m_idle = 0; m_remote = 0;
    end else if (m_state == 4) begin
    end else if (!en) begin
      m_state = 0; m_run = 0; m_hunt = 0; m_idle = 0; m_remote = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_hunt = 0; m_run = 0;
    end else if (m_state == 1 || m_state == 2) begin
      m_hunt++;
      if (m_hunt >= LT) m_state = 4;
      else if (is_train) begin
        m_run++;
        m_state = (m_run >= LC) ? 3 : 2;
        m_idle = 0;
      end else if (vld) begin
        m_run = 0; m_state = 1;
      end
    end else begin
      if (vld) begin
        m_idle = 0;
        if (is_train && dat[0]) m_remote = 1;
      end else begin
        m_idle++;
        if (m_idle >= GL) begin m_state = 4; m_remote = 0; end
      end
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(st), 32'(m_state));
    chk("rx_ready", 32'(rdy), 32'(m_state == 3));
    chk("remote_ready", 32'(rrdy), 32'(m_remote && m_state == 3));
    chk("fault", 32'(flt), 32'(m_state == 4));
  endtask

  task automatic step(logic r, logic e, logic v, logic [63:0] d);
    @(negedge clk);
    rst = r; en = e; vld = v; dat = d;
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  initial begin
    rst = 1; en = 0; vld = 0; dat = '0;
    m_state = 0; m_run = 0; m_hunt = 0; m_idle = 0; m_remote = 0;
    step(1, 0, 0, 0);
    step(1, 1, 1, tw(1));
    chk("reset_state_lit", 32'(st), 0);
    chk("reset_fault_lit", 32'(flt), 0);
    // basic lock with four training words
    step(0, 1, 0, 0);
    chk("hunt_lit", 32'(st), 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, tw(0));
    chk("locking_lit", 32'(st), 2);
    step(0, 1, 1, tw(0));
    chk("locked_lit", 32'(st), 3);
    chk("ready_lit", 32'(rdy), 1);
    // remote flag while locked, then disable
    step(0, 1, 1, tw(1));
    chk("remote_lit", 32'(rrdy), 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, dw());
    chk("remote_sticky_lit", 32'(rrdy), 1);
    step(0, 0, 0, 0);
    chk("disable_state_lit", 32'(st), 0);
    chk("disable_remote_lit", 32'(rrdy), 0);
    // broken run, then a run with an idle gap inside
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, tw(1));
    step(0, 1, 1, dw());
    chk("broken_run_lit", 32'(st), 1);
    step(0, 1, 1, tw(0));
    step(0, 1, 1, tw(0));
    step(0, 1, 0, 0);
    step(0, 1, 1, tw(0));
    chk("gap_in_run_lit", 32'(st), 2);
    chk("early_flag_ignored_lit", 32'(rrdy), 0);
    step(0, 1, 1, tw(0));
    chk("relock_lit", 32'(st), 3);
    // gap tolerance
    for (int i = 0; i < GL - 1; i++) step(0, 1, 0, 0);
    step(0, 1, 1, dw());
    chk("gap_ok_lit", 32'(flt), 0);
    for (int i = 0; i < GL - 1; i++) step(0, 1, 0, 0);
    chk("gap_edge_lit", 32'(flt), 0);
    step(0, 1, 0, 0);
    chk("gap_fault_lit", 32'(flt), 1);
    chk("gap_fault_ready_lit", 32'(rdy), 0);
    for (int i = 0; i < 6; i++) step(0, i[0], 1, tw(1));
    chk("fault_sticky_lit", 32'(st), 4);
    step(1, 1, 0, 0);
    chk("fault_reset_lit", 32'(flt), 0);
    // timeout while hunting on data words only
    step(0, 1, 0, 0);
    for (int i = 0; i < LT - 1; i++) step(0, 1, 1, dw());
    chk("pre_timeout_lit", 32'(st), 1);
    step(0, 1, 1, dw());
    chk("timeout_lit", 32'(flt), 1);
    step(1, 1, 0, 0);
    chk("timeout_reset_lit", 32'(st), 0);
    // reset mid-locking requires a fresh full run
    step(0, 1, 0, 0);
    step(0, 1, 1, tw(0));
    step(0, 1, 1, tw(0));
    step(1, 1, 1, tw(0));
    chk("mid_lock_reset_lit", 32'(st), 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, tw(0));
    chk("fresh_run_lit", 32'(st), 2);
    step(0, 1, 1, tw(0));
    chk("fresh_lock_lit", 32'(st), 3);
    // randomized traffic with phases of varying idle density
    for (int p = 0; p < 8; p++) begin
      int vp;
      vp = $urandom_range(30, 98);
      for (int i = 0; i < 500; i++) begin
        logic r, e, v;
        r = ($urandom_range(0, 199) == 0);
        e = ($urandom_range(0, 99) < 96);
        v = ($urandom_range(0, 99) < vp);
        step(r, e, v, ($urandom_range(0, 99) < 75) ? tw(1'($urandom)) : dw());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qeciphy_rx_lock_monitor.md
QECIPHY_RX_LOCK_MONITOR -- requirements
Module: qeciphy_rx_lock_monitor

Interface
REQ-001 Parameter LOCK_COUNT, default 64: consecutive training words required for local lock (range 1..1023).
REQ-002 Parameter GAP_LIMIT, default 256: consecutive idle cycles tolerated in LOCKED before fault (range 2..65535).
REQ-003 Parameter LOCK_TIMEOUT, default 1048575: maximum cycles in HUNT/LOCKING before fault (range 2..2^20-1).
REQ-004 Parameter TRAIN_MARKER, default 16'hB5A3: value of rx_data_i[63:48] identifying a training word.
REQ-005 clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 rx_enable_i  input  1  RX processing enable from link controller.
REQ-008 rx_valid_i  input  1  rx_data_i carries a word this cycle.
REQ-009 rx_data_i  input  64  aligned received word.
REQ-010 rx_ready_o  output  1  local RX frame lock achieved (feeds controller rx_ready_i).
REQ-011 remote_rx_ready_o  output  1  remote side reports its RX locked (feeds controller remote_rx_ready_i).
REQ-012 fault_fatal_o  output  1  lock-loss/timeout fault (feeds controller fault_fatal_i).
REQ-013 state_o  output  3  state code: IDLE=0, HUNT=1, LOCKING=2, LOCKED=3, FAULT=4.

Function
REQ-014 Training word: rx_valid_i=1 and rx_data_i[63:48]==TRAIN_MARKER; rx_data_i[0] is the remote-ready flag; any other valid word is a data word.
REQ-015 All outputs registered; no combinational input-to-output path.
REQ-016 Edge priority: rst_i > FAULT hold > rx_enable_i=0 > timeout/gap fault > word processing.
REQ-017 IDLE: counters cleared; rx_enable_i=1 -> HUNT next edge.
REQ-018 HUNT: training word -> LOCKING, lock count=1; data words and idle cycles ignored.
REQ-019 LOCKING: training word increments lock count; data word -> HUNT, lock count=0; idle cycles neither increment nor clear.
REQ-020 LOCKING: edge capturing the LOCK_COUNT-th consecutive training word -> LOCKED; with LOCK_COUNT=1 the HUNT training word goes directly to LOCKED.
REQ-021 Timeout counter: cleared on entry to HUNT from IDLE, increments every cycle in HUNT/LOCKING (not cleared by HUNT<->LOCKING moves), saturating 20-bit; reaching LOCK_TIMEOUT -> FAULT next edge.
REQ-022 rx_ready_o=1 exactly while state is LOCKED.
REQ-023 LOCKED: gap counter increments each cycle with rx_valid_i=0, clears on any rx_valid_i=1; edge ending the GAP_LIMIT-th consecutive idle cycle -> FAULT; rx_valid_i=1 in that cycle clears counter, no fault.
REQ-024 LOCKED: training word with rx_data_i[0]=1 sets remote_rx_ready_o next edge; sticky until IDLE, FAULT or reset; data words never affect it.
REQ-025 Training words with rx_data_i[0]=1 received before LOCKED do not set remote_rx_ready_o.
REQ-026 FAULT: fault_fatal_o=1, rx_ready_o=0, remote_rx_ready_o=0; sticky until rst_i regardless of rx_enable_i.
REQ-027 rx_enable_i=0 in any non-FAULT state -> IDLE next edge; all counters and remote_rx_ready_o cleared.
REQ-028 Counter widths: lock count clog2(LOCK_COUNT+1), gap count clog2(GAP_LIMIT+1); no wrap possible.

Reset
REQ-029 rst_i=1 at an edge: state IDLE, all counters 0, rx_ready_o=0, remote_rx_ready_o=0, fault_fatal_o=0, state_o=0, including mid-LOCKING or in FAULT.
REQ-030 Outputs reach reset values on the first edge with rst_i=1; first transition possible on the first edge with rst_i=0.

Verification
REQ-031 LOCK_COUNT=4: enable, 4 back-to-back training words (flag 0) -> rx_ready_o=1 one cycle after 4th word; state_o=3.
REQ-032 LOCK_COUNT=4: 3 training words, 1 data word, 4 training words -> LOCKED only after the final 4th; idle gaps inside the run do not reset count.
REQ-033 Locked; training word flag=1 -> remote_rx_ready_o=1 next cycle; subsequent data words keep it 1; rx_enable_i=0 -> state_o=0, both ready outputs 0.
REQ-034 GAP_LIMIT=8: locked, 7 idle cycles then valid word -> no fault; then 8 idle cycles -> fault_fatal_o=1, rx_ready_o=0; persists with rx_enable_i toggled until rst_i.
REQ-035 LOCK_TIMEOUT=100: enable, only data words -> fault_fatal_o=1 after 100 cycles in HUNT; rst_i pulse -> all outputs 0, state_o=0.
REQ-036 Reset asserted mid-LOCKING (count=2) -> state_o=0 next cycle; re-enable requires full LOCK_COUNT fresh training words.
